// File: rtl/line_buffer_multi_if.sv
// line_buffer_multi_if: pixel-stream bundle for line_buffer_multi.
//   ce         sample enable (one accepted sample per clk edge with ce=1)
//   flush      synchronous frame restart, independent of ce
//   h_size     line length in samples (valid range 4..2^ADDR_W)
//   din        input sample
//   dout       LINES taps, tap k at [(k+1)*WIDTH-1 : k*WIDTH]
//   line_valid bit k: tap k holds data of the current frame
//   cfg_err    h_size out of range at frame start
// master: stream source / consumer side; slave: the line buffer.
interface line_buffer_multi_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LINES  = 2,
  parameter int unsigned ADDR_W = 11
);
  logic                   ce;
  logic                   flush;
  logic [ADDR_W:0]        h_size;
  logic [WIDTH-1:0]       din;
  logic [LINES*WIDTH-1:0] dout;
  logic [LINES-1:0]       line_valid;
  logic                   cfg_err;

  modport master (
    output ce, flush, h_size, din,
    input  dout, line_valid, cfg_err
  );

  modport slave (
    input  ce, flush, h_size, din,
    output dout, line_valid, cfg_err
  );
endinterface

// File: rtl/line_buffer_multi.sv
// line_buffer_multi: multi-line delay buffer for neighbourhood filters.
// Tap k presents din delayed by exactly (k+1)*h_len accepted samples.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  line_buffer_multi_if.slave (ce, flush, h_size, din, dout,
//        line_valid, cfg_err)
// Optional macro LINEBUF_ZERO_FILL_EN: taps read zero while their
// line_valid bit is low (zero-padded borders). Without it, invalid taps
// carry stale RAM/pipeline content and must be qualified by line_valid.
module line_buffer_multi #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LINES  = 2,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  line_buffer_multi_if.slave  bus
);

  // Holds LINES*2^ADDR_W (LINES <= 8) without overflow.
  localparam int unsigned CNT_W = ADDR_W + 4;
  localparam logic [ADDR_W:0] H_MIN = (ADDR_W+1)'(4);
  localparam logic [ADDR_W:0] H_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN, ERR} state_t;

  state_t                       state;
  logic [ADDR_W:0]              h_len;
  logic [ADDR_W-1:0]            addr0;
  logic [ADDR_W-1:0]            addr1;
  logic [CNT_W-1:0]             cnt;
  logic [LINES-1:0]             valid_q;
  logic [LINES-1:0]             valid_nx;
  logic [LINES-1:0][WIDTH-1:0]  tap_q;
  logic                         cfg_err_q;
  logic                         h_ok;
  logic                         accept;
  logic [ADDR_W-1:0]            addr0_nx;
  logic [ADDR_W-1:0]            addr1_nx;
  logic [WIDTH-1:0]             rd_data [LINES];

  always_comb begin
    h_ok   = (bus.h_size >= H_MIN) && (bus.h_size <= H_MAX);
    accept = !bus.flush && bus.ce &&
             ((state == FILL) || (state == RUN) || ((state == IDLE) && h_ok));

    // Line 0 has depth h_len. Cascaded lines are fed from the previous
    // registered tap, which already adds one sample, so they use h_len-1.
    if (state == IDLE)
      addr0_nx = ADDR_W'(1);
    else if ({1'b0, addr0} == h_len - (ADDR_W+1)'(1))
      addr0_nx = '0;
    else
      addr0_nx = addr0 + 1'b1;

    if (state == IDLE)
      addr1_nx = ADDR_W'(1);
    else if ({1'b0, addr1} == h_len - (ADDR_W+1)'(2))
      addr1_nx = '0;
    else
      addr1_nx = addr1 + 1'b1;

    // Tap k first shows sample 0 on the edge where (k+1)*h_len samples
    // have already been accepted in this frame.
    valid_nx = valid_q;
    if ((state == FILL) || (state == RUN)) begin
      for (int unsigned k = 0; k < LINES; k++) begin
        if (cnt == CNT_W'(k + 1) * CNT_W'(h_len))
          valid_nx[k] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LINES; g++) begin : g_line
    logic [WIDTH-1:0]  mem [2**ADDR_W];
    logic [ADDR_W-1:0] a;
    logic [WIDTH-1:0]  wr;
    if (g == 0) begin : g_head
      assign a  = addr0;
      assign wr = bus.din;
    end else begin : g_casc
      assign a  = addr1;
      assign wr = tap_q[g-1];
    end
    // Read-first: the tap register captures the old word in the same edge.
    always_ff @(posedge clk) begin
      if (accept)
        mem[a] <= wr;
    end
    assign rd_data[g] = mem[a];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      h_len     <= '0;
      addr0     <= '0;
      addr1     <= '0;
      cnt       <= '0;
      valid_q   <= '0;
      tap_q     <= '0;
      cfg_err_q <= 1'b0;
    end else if (bus.flush) begin
      state     <= IDLE;
      addr0     <= '0;
      addr1     <= '0;
      cnt       <= '0;
      valid_q   <= '0;
      cfg_err_q <= 1'b0;
`ifdef LINEBUF_ZERO_FILL_EN
      tap_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          h_len <= bus.h_size;
          if (bus.ce) begin
            if (h_ok) begin
              state <= FILL;
            end else begin
              state     <= ERR;
              cfg_err_q <= 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.ce && valid_nx[LINES-1])
            state <= RUN;
        end
        RUN:  state <= RUN;
        ERR:  state <= ERR;
      endcase

      if (accept) begin
        addr0   <= addr0_nx;
        addr1   <= addr1_nx;
        valid_q <= valid_nx;
        if (state != RUN)
          cnt <= cnt + 1'b1;
        for (int unsigned k = 0; k < LINES; k++) begin
`ifdef LINEBUF_ZERO_FILL_EN
          tap_q[k] <= valid_nx[k] ? rd_data[k] : '0;
`else
          tap_q[k] <= rd_data[k];
`endif
        end
      end
    end
  end

  assign bus.dout       = tap_q;
  assign bus.line_valid = valid_q;
  assign bus.cfg_err    = cfg_err_q;

endmodule

// File: doc/line_buffer_multi.md
# line_buffer_multi

Parametrised multi-line delay buffer for neighbourhood filters such as median and 3x3/5x5 windows. It delays a pixel stream by 1..LINES full image lines of runtime-configurable length and presents all delayed taps at once. It replaces the single fixed-line BRAM delay line with inferred RAM, cascaded lines and exact delay with no caller-side latency correction. It also tracks per-line fill status and supports a synchronous flush between frames.

## Interface
- WIDTH, 16, pixel/sample width in bits
- LINES, 2, number of delayed lines (1..8); 2 feeds a 3x3 window
- ADDR_W, 11, line-length address width; max line length 2^ADDR_W
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  sample enable; one input sample accepted per clk edge with ce=1
- flush  in  1  synchronous restart (frame boundary), independent of ce
- h_size  in  ADDR_W+1  line length in samples, valid range 4..2^ADDR_W
- din  in  WIDTH  input sample
- dout  out  LINES*WIDTH  tap k at bits [(k+1)*WIDTH-1 : k*WIDTH]
- line_valid  out  LINES  bit k: tap k holds real data of the current frame
- cfg_err  out  1  h_size out of range at frame start

## Operation
- Tap k equals din delayed by exactly (k+1)*h_len accepted samples. h_len is the latched line length.
- Accepted sample: a clk edge with ce=1 while in FILL or RUN, or the edge that leaves IDLE.
- FSM states: IDLE, FILL, RUN, ERR.
  - IDLE: h_len <= h_size every clock. On ce=1 with h_size in range -> FILL, and this sample is the first accepted. On ce=1 with h_size out of range -> ERR, cfg_err=1.
  - FILL: accept samples. After accepted count reaches (k+1)*h_len, line_valid[k] rises. When line_valid[LINES-1] rises -> RUN.
  - RUN: steady state. All line_valid bits are 1. Accepted count saturates and is not used.
  - ERR: ce ignored, outputs hold. Only flush or rst leaves this state (-> IDLE).
- flush=1 (any state, any ce): -> IDLE next edge. Clears line_valid, cfg_err, the address counters and the fill counter. RAM contents are not cleared. flush has priority over ce in the same cycle, and that sample is not accepted.
- Address counters wrap from their last index to 0 with no gap. The wrap is exact for any h_len in range, including non-powers of two.
- The line length is constant within a frame. Changing h_size outside IDLE has no effect until the next flush or rst.
- Storage: one inferred simple-dual-port or read-first RAM per line, depth 2^ADDR_W. Cascade lines from the previous tap's registered output, with a correspondingly shortened depth, so the delay stays exact.
- No arithmetic on data. The accepted-sample counter is sized to hold LINES*2^ADDR_W without overflow.

## Timing
- Reset values: dout=0, line_valid=0, cfg_err=0, state=IDLE, all counters 0, h_len=0.
- dout and line_valid are registered. They update only on edges with an accepted sample and hold otherwise.
- Latency: after the edge accepting sample n, tap k shows sample n-(k+1)*h_len.
- line_valid[k] goes high on the same edge that first makes tap k show sample 0 of the frame.
- cfg_err is set on the edge that enters ERR and stays until flush or rst.
- rst asserted mid-frame: all outputs go to reset values immediately (asynchronous). Operation resumes in IDLE after rst is released.
- Throughput: one sample per clock sustained. ce may toggle arbitrarily, and gaps do not alter the delay count.

## Configuration
- Macro LINEBUF_ZERO_FILL_EN.
- Defined: while line_valid[k]=0, tap k outputs zero. Use for zero-padded borders.
- Undefined: while line_valid[k]=0, tap k outputs raw stale RAM/pipeline content. line_valid must be used to qualify the tap.
- In RUN, behaviour is identical with or without the macro.

## Test plan
- LINES=2, h_size=8, ce=1, din=0,1,2,...: tap0 shows 0 after the edge accepting sample 8. tap1 shows 0 after the edge accepting sample 16. line_valid=01 then 11, and the FSM enters RUN on sample 16.
- Same config with ce toggling pseudo-randomly: tap values versus accepted-sample index match the continuous-ce run exactly, and outputs hold on ce=0.
- h_size=5 (non-power-of-two) for 100 samples: tap0 = n-5 and tap1 = n-10 at every accepted n≥10. No wrap glitch.
- h_size=2 then ce=1: cfg_err=1, state ERR, dout unchanged. A flush with h_size=8 then operates normally.
- Flush asserted with ce=1 at sample 20: that sample is not accepted and line_valid=00. The next frame refills in 16 samples. With LINEBUF_ZERO_FILL_EN, taps read 0 during refill.
- rst pulse mid-RUN (asynchronous, between edges): dout=0 and line_valid=0 before the next clk edge. Operation after release matches a cold start.
